// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings and parameter defaults.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rxState_t;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int OVS_DEFAULT    = 16;

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversample tick generator: one-clk tick every TICK_COUNT clocks, realigned by clear.
module baud_tick_gen #(
  parameter int TICK_COUNT = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_COUNT - 1);

  logic [CW-1:0] divCnt;

  // Down-counter; terminal count at zero produces the tick and reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
      tick   <= 1'b0;
    end else if (clear) begin
      divCnt <= RELOAD;
      tick   <= 1'b0;
    end else if (divCnt == '0) begin
      divCnt <= RELOAD;
      tick   <= 1'b1;
    end else begin
      divCnt <= divCnt - 1'b1;
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, frame-error/break handling
// and overrun reporting toward a downstream FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | qualifying the start bit at its midpoint
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit, deciding write/overrun/frame error
// BREAK | line stuck low after a frame error, waiting for it to go high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int BAUD_RATE  = 9600,
  parameter int OVS        = OVS_DEFAULT,
  parameter int TICK_COUNT = CLK_HZ / (BAUD_RATE * OVS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  input  logic       full,
  output logic       wrEn,
  output logic [7:0] din,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVS - 1);

  rxState_t      state;
  logic          rxMeta, rxSync, rxPrev;
  logic          tick;
  logic          fallEdge;
  logic          startEdge;
  logic [TW-1:0] tickCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rxData;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign fallEdge  = rxPrev & ~rxSync;
  assign startEdge = (state == IDLE) & fallEdge;
  assign busy      = (state != IDLE);

  baud_tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .clear(startEdge),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      din      <= '0;
      wrEn     <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wrEn     <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (fallEdge) begin
            state   <= START;
            tickCnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tickCnt == MID_TICK) begin
              tickCnt <= '0;
              bitCnt  <= '0;
              state   <= rxSync ? IDLE : DATA;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tickCnt == LAST_TICK) begin
              tickCnt  <= '0;
              shiftReg <= {rxSync, shiftReg[7:1]};
              bitCnt   <= bitCnt + 1'b1;
              if (bitCnt == 3'd7) state <= STOP;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tickCnt == LAST_TICK) begin
              tickCnt <= '0;
              if (rxSync) begin
                // full only matters here; a full FIFO drops the good byte
                if (full) begin
                  overrun <= 1'b1;
                end else begin
                  wrEn <= 1'b1;
                  din  <= shiftReg;
                end
                state <= IDLE;
              end else begin
                frameErr <= 1'b1;
                state    <= BREAK;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rxSync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: fast clock ratio (4 clks/tick, 64 clks/bit) with hand-computed expectations.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxData;
  logic       full;
  logic       wrEn;
  logic [7:0] din;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int wrCount = 0, feCount = 0, ovCount = 0, multiCount = 0;
  logic [7:0] dinLog [16];
  int wrBase, feBase, ovBase, multiBase;

  uart_rx #(
    .CLK_HZ   (614_400),
    .BAUD_RATE(9600),
    .OVS      (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxData  (rxData),
    .full    (full),
    .wrEn    (wrEn),
    .din     (din),
    .frameErr(frameErr),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrEn) begin
      dinLog[wrCount[3:0]] <= din;
      wrCount <= wrCount + 1;
    end
    if (frameErr) feCount <= feCount + 1;
    if (overrun) ovCount <= ovCount + 1;
    if ((32'(wrEn) + 32'(frameErr) + 32'(overrun)) > 1) multiCount <= multiCount + 1;
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wrBase = wrCount;
    feBase = feCount;
    ovBase = ovCount;
    multiBase = multiCount;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; line is left at the stop level.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                           input logic fullData, input logic fullStop);
    rxData = 1'b0;
    waitClk(BIT_CLKS);
    full = fullData;
    for (int i = 0; i < 8; i++) begin
      rxData = b[i];
      waitClk(BIT_CLKS);
    end
    full = fullStop;
    rxData = stopBit;
    waitClk(BIT_CLKS);
  endtask

  initial begin
    rst = 1'b1;
    rxData = 1'b1;
    full = 1'b0;
    waitClk(3);
    check("rst_wrEn", 16'(wrEn), 16'h0);
    check("rst_din", 16'(din), 16'h00);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_frameErr", 16'(frameErr), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    rst = 1'b0;
    waitClk(2 * BIT_CLKS);

    // single byte 0xA5
    snap();
    sendFrame(8'hA5, 1'b1, 1'b0, 1'b0);
    waitClk(BIT_CLKS);
    check("a5_writes", 16'(wrCount - wrBase), 16'd1);
    check("a5_din", 16'(din), 16'h00A5);
    check("a5_frameErr", 16'(feCount - feBase), 16'd0);
    check("a5_overrun", 16'(ovCount - ovBase), 16'd0);
    check("a5_busy_idle", 16'(busy), 16'h0);

    // back-to-back 0x00 then 0xFF with no idle gap
    snap();
    sendFrame(8'h00, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hFF, 1'b1, 1'b0, 1'b0);
    waitClk(BIT_CLKS);
    check("b2b_writes", 16'(wrCount - wrBase), 16'd2);
    check("b2b_din0", 16'(dinLog[wrBase[3:0]]), 16'h0000);
    check("b2b_din1", 16'(dinLog[4'(wrBase + 1)]), 16'h00FF);

    // 3-tick low glitch: false start, back to IDLE before tick 9
    snap();
    rxData = 1'b0;
    waitClk(12);
    rxData = 1'b1;
    check("glitch_busy_high", 16'(busy), 16'h1);
    waitClk(26);
    check("glitch_busy_low", 16'(busy), 16'h0);
    waitClk(2 * BIT_CLKS);
    check("glitch_writes", 16'(wrCount - wrBase), 16'd0);
    check("glitch_frameErr", 16'(feCount - feBase), 16'd0);

    // 0x3C with low stop bit, line held low (break), then 0x55
    snap();
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    waitClk(20 * BIT_CLKS);
    check("brk_busy_in_break", 16'(busy), 16'h1);
    check("brk_frameErr", 16'(feCount - feBase), 16'd1);
    check("brk_no_write", 16'(wrCount - wrBase), 16'd0);
    rxData = 1'b1;
    waitClk(2 * BIT_CLKS);
    check("brk_busy_released", 16'(busy), 16'h0);
    sendFrame(8'h55, 1'b1, 1'b0, 1'b0);
    waitClk(BIT_CLKS);
    check("brk_writes", 16'(wrCount - wrBase), 16'd1);
    check("brk_din55", 16'(din), 16'h0055);
    check("brk_frameErr_total", 16'(feCount - feBase), 16'd1);

    // 0x81 with full at stop -> overrun; then full toggled mid-frame but clear at stop -> write
    snap();
    sendFrame(8'h81, 1'b1, 1'b0, 1'b1);
    waitClk(BIT_CLKS);
    full = 1'b0;
    check("ovr_overrun", 16'(ovCount - ovBase), 16'd1);
    check("ovr_no_write", 16'(wrCount - wrBase), 16'd0);
    check("ovr_din_held", 16'(din), 16'h0055);
    sendFrame(8'h81, 1'b1, 1'b1, 1'b0);
    waitClk(BIT_CLKS);
    check("ovr_then_write", 16'(wrCount - wrBase), 16'd1);
    check("ovr_din81", 16'(din), 16'h0081);
    check("ovr_overrun_total", 16'(ovCount - ovBase), 16'd1);

    // reset in the middle of 0xF0 (during data bit 4), then 0x12
    snap();
    rxData = 1'b0;
    waitClk(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxData = 1'b0;
      waitClk(BIT_CLKS);
    end
    rxData = 1'b1;
    waitClk(20);
    check("mid_busy_before_rst", 16'(busy), 16'h1);
    rst = 1'b1;
    waitClk(3);
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_din", 16'(din), 16'h0000);
    rst = 1'b0;
    waitClk(2 * BIT_CLKS);
    sendFrame(8'h12, 1'b1, 1'b0, 1'b0);
    waitClk(BIT_CLKS);
    check("mid_writes", 16'(wrCount - wrBase), 16'd1);
    check("mid_din12", 16'(din), 16'h0012);
    check("mid_frameErr", 16'(feCount - feBase), 16'd0);

    check("pulses_exclusive", 16'(multiCount), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
